regfile_seq_ctrl: RTL and testbench
===================================

Name: regfile_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the 8-bit, 4-entry register file.
- Accepts one 8-bit instruction per valid/ready handshake.
- Drives register-file read/write addressing, REGDST and REGWRITE, plus ALU select and sign-extended immediate to the datapath.
- Implements a conditional skip of the next instruction. Sits between the instruction source and the register file/ALU.

Parameters:
- DATA_W, 8, register/ALU data width
- ADDR_W, 2, register address width (4 registers)
- IMM_W, 2, immediate field width, sign-extended to DATA_W

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- INSTR  in  8  instruction: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm
- INSTR_VALID  in  1  instruction present
- INSTR_READY  out  1  controller can accept (IDLE only)
- RD_ONE  in  DATA_W  register-file READ_DATA_ONE
- RD_TWO  in  DATA_W  register-file READ_DATA_TWO
- REG_SOURCE  out  ADDR_W  read port 1 address (rs)
- REG_TWO  out  ADDR_W  read port 2 address / I-type write address (rt)
- REG_DEST  out  ADDR_W  R-type write address (rd)
- REGDST  out  1  1 = write rd, 0 = write rt
- REGWRITE  out  1  write strobe to register file
- ALU_OP  out  2  00 add, 01 sub, 10 add-immediate
- ALU_SRC  out  1  1 = ALU operand B is IMM_EXT
- IMM_EXT  out  DATA_W  sign-extended instr[1:0]
- DONE  out  1  one-cycle pulse when an instruction retires (including skipped)

Behaviour:
- Opcodes:
  - 00 ADD: rd = rs + rt
  - 01 SUB: rd = rs - rt
  - 10 ADDI: rt = rs + sext(imm)
  - 11 SKE: if R[rs] == R[rt], the next accepted instruction is squashed; never writes
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: INSTR_READY = 1. When INSTR_VALID is high, latch INSTR into instr_q and go to READ.
  - READ: drive REG_SOURCE = rs and REG_TWO = rt. The register file registers its read data at this edge. Go to EXEC.
  - EXEC: RD_ONE/RD_TWO are valid. Hold the read addresses and drive ALU_OP, ALU_SRC, IMM_EXT. For SKE, compute eq = (RD_ONE == RD_TWO). Go to WB.
  - WB: DONE = 1.
    - REGWRITE = 1 for ops 00/01/10 unless squash_q is set.
    - REGDST = 1 for 00/01, 0 for 10. REG_TWO stays rt so that REGDST = 0 writes rt.
    - squash_q update: set to eq if op is SKE; otherwise cleared, so it is consumed by this instruction.
    - A squashed SKE sets no new skip.
    - Go to IDLE.
- Throughput: accept at edge N gives READ at N+1, EXEC at N+2, WB at N+3. The write lands at the end of WB. INSTR_READY rises in cycle N+4, for 4 cycles per instruction.
- An instruction reads results of its predecessor correctly: the write completes before the next READ.
- INSTR_VALID is ignored outside IDLE. INSTR is sampled only on the accept edge.
- Outputs outside WB: REGWRITE = 0 and DONE = 0. Addresses and ALU controls hold instr_q fields from READ through WB and are 0 in IDLE.
- Arithmetic is modulo 2^DATA_W (datapath concern). The controller only selects operations.
- Reset, including mid-instruction:
  - State goes to IDLE, squash_q = 0, instr_q = 0.
  - All outputs return to 0, except INSTR_READY = 1 once RST deasserts.
  - The in-flight instruction is dropped with no write.
- Back-to-back SKE with equal operands: the second SKE is squashed and does not arm a further skip.

Optional Feature:
- Macro CTRL_RETIRE_CNT_EN.
- When defined: adds outputs RETIRE_CNT[7:0] and SQUASH_CNT[7:0].
  - RETIRE_CNT counts DONE pulses. SQUASH_CNT counts WB cycles with squash_q = 1.
  - Both are reset to 0 by RST and wrap 255→0.
- When undefined: the ports and logic are absent, with otherwise identical behaviour.

Decomposition:
- Shared package regfile_ctrl_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_ADDI/OP_SKE
  - ALU_OP encodings
  - state encoding IDLE/READ/EXEC/WB
  - field bit positions
- One natural sub-module: regfile_seq_decode, combinational op → {REGDST, writes, ALU_OP, ALU_SRC, is_ske}. The FSM, squash flag and counters stay in the top.

Test Plan:
- Reset, then INSTR = 8'b10_00_01_01 (ADDI r1 = r0 + 1) held valid → accept at edge 1, REGWRITE = 1 with REGDST = 0, REG_TWO = 1, IMM_EXT = 8'h01 in cycle 4, DONE pulse, INSTR_READY high in cycle 5.
- ADD r3 = r1 + r2 (8'b00_01_10_11) with RD_ONE = 5, RD_TWO = 7 → EXEC ALU_OP = 00, ALU_SRC = 0; WB REGDST = 1, REG_DEST = 3, REGWRITE = 1.
- ADDI with imm = 2'b11 → IMM_EXT = 8'hFF, ALU_OP = 10, ALU_SRC = 1.
- SKE r0, r1 with RD_ONE = RD_TWO = 8'h00, then ADD → the ADD retires with DONE = 1 and REGWRITE = 0. A following ADD writes normally.
- SKE with RD_ONE = 3, RD_TWO = 4, then ADD → no squash, ADD writes. SKE(equal), SKE(equal), ADD → the second SKE is squashed and the ADD writes.
- Assert RST during EXEC of an ADD → REGWRITE never pulses, DONE stays 0, INSTR_READY = 1 the cycle after release, squash_q cleared. With CTRL_RETIRE_CNT_EN, 256 retirements wrap RETIRE_CNT to 0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared definitions for the register-file instruction sequencer:
//   - opcode constants (instr[7:6])
//   - ALU_OP encodings driven to the datapath
//   - FSM state encoding
//   - instruction field bit positions
//   - decoded-control bundle passed from the decoder to the top
// ----------------------------------------------------------------------------
package regfile_ctrl_pkg;

    // Opcodes
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_SKE  = 2'b11;

    // ALU_OP encodings
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ADDI = 2'b10;

    // Instruction field positions: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm
    localparam int OP_LO  = 6;
    localparam int RS_LO  = 4;
    localparam int RT_LO  = 2;
    localparam int RD_LO  = 0;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Decoded control for one opcode
    typedef struct packed {
        logic       reg_dst;   // 1 = write rd, 0 = write rt
        logic       writes;    // opcode writes the register file
        logic [1:0] alu_op;
        logic       alu_src;   // 1 = ALU operand B is the immediate
        logic       is_ske;
    } dec_t;

endpackage

// File: rtl/regfile_seq_decode.sv
// ----------------------------------------------------------------------------
// regfile_seq_decode
// Purely combinational opcode decoder.
// Ports:
//   op   in   2      instruction opcode
//   dec  out  dec_t  {reg_dst, writes, alu_op, alu_src, is_ske}
// ----------------------------------------------------------------------------
module regfile_seq_decode
    import regfile_ctrl_pkg::*;
(
    input  logic [1:0] op,
    output dec_t       dec
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        dec = '0;
        case (op)
            OP_ADD: begin
                dec.reg_dst = 1'b1;
                dec.writes  = 1'b1;
                dec.alu_op  = ALU_ADD;
            end
            OP_SUB: begin
                dec.reg_dst = 1'b1;
                dec.writes  = 1'b1;
                dec.alu_op  = ALU_SUB;
            end
            OP_ADDI: begin
                dec.writes  = 1'b1;
                dec.alu_op  = ALU_ADDI;
                dec.alu_src = 1'b1;
            end
            default: begin
                // SKE compares operands; subtract is the natural ALU hint.
                dec.alu_op  = ALU_SUB;
                dec.is_ske  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_seq_ctrl
// Multi-cycle (IDLE -> READ -> EXEC -> WB) sequencer for an 8-bit, 4-entry
// register file. Accepts one instruction per valid/ready handshake, drives
// register addresses, REGDST/REGWRITE, ALU select and sign-extended
// immediate, and implements SKE (skip next instruction if R[rs] == R[rt]).
//
// Ports:
//   CLK, RST             clock (rising), asynchronous active-high reset
//   INSTR, INSTR_VALID   instruction and its valid strobe
//   INSTR_READY          high in IDLE (and not in reset)
//   RD_ONE, RD_TWO       registered read data from the register file
//   REG_SOURCE, REG_TWO  read addresses rs / rt (REG_TWO is also I-type dest)
//   REG_DEST             R-type write address rd
//   REGDST, REGWRITE     write select and write strobe (WB only)
//   ALU_OP, ALU_SRC      ALU operation and operand-B select
//   IMM_EXT              sign-extended immediate
//   DONE                 one-cycle retire pulse (also for squashed instrs)
//
// Optional: define CTRL_RETIRE_CNT_EN to add RETIRE_CNT[7:0] (DONE pulses)
// and SQUASH_CNT[7:0] (WB cycles of squashed instructions), both wrapping.
// ----------------------------------------------------------------------------
module regfile_seq_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int IMM_W  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        INSTR,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    input  logic [DATA_W-1:0] RD_ONE,
    input  logic [DATA_W-1:0] RD_TWO,
    output logic [ADDR_W-1:0] REG_SOURCE,
    output logic [ADDR_W-1:0] REG_TWO,
    output logic [ADDR_W-1:0] REG_DEST,
    output logic              REGDST,
    output logic              REGWRITE,
    output logic [1:0]        ALU_OP,
    output logic              ALU_SRC,
    output logic [DATA_W-1:0] IMM_EXT,
    output logic              DONE
`ifdef CTRL_RETIRE_CNT_EN
   ,output logic [7:0]        RETIRE_CNT,
    output logic [7:0]        SQUASH_CNT
`endif
);

    state_t     state_q, state_d;
    logic [7:0] instr_q;
    logic       squash_q;   // current instruction is skipped
    logic       eq_q;       // SKE compare result captured in EXEC
    dec_t       dec;

    regfile_seq_decode u_decode (
        .op  (instr_q[OP_LO +: 2]),
        .dec (dec)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            squash_q <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (state_q == IDLE && INSTR_VALID)
                instr_q <= INSTR;
            // Read data is only valid in EXEC; keep the compare for WB.
            if (state_q == EXEC)
                eq_q <= (RD_ONE == RD_TWO);
            // A squashed instruction consumes the skip; only a live SKE
            // can arm a new one.
            if (state_q == WB)
                squash_q <= dec.is_ske && !squash_q && eq_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        INSTR_READY = 1'b0;
        REG_SOURCE  = '0;
        REG_TWO     = '0;
        REG_DEST    = '0;
        REGDST      = 1'b0;
        REGWRITE    = 1'b0;
        ALU_OP      = '0;
        ALU_SRC     = 1'b0;
        IMM_EXT     = '0;
        DONE        = 1'b0;

        case (state_q)
            IDLE: begin
                // Held low while RST is asserted so every output reads 0.
                INSTR_READY = !RST;
                if (INSTR_VALID)
                    state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                state_d  = IDLE;
                DONE     = 1'b1;
                REGWRITE = dec.writes && !squash_q;
                REGDST   = dec.reg_dst;
            end
            default: state_d = IDLE;
        endcase

        // Address and ALU controls hold from READ through WB.
        if (state_q != IDLE) begin
            REG_SOURCE = instr_q[RS_LO +: ADDR_W];
            REG_TWO    = instr_q[RT_LO +: ADDR_W];
            REG_DEST   = instr_q[RD_LO +: ADDR_W];
            ALU_OP     = dec.alu_op;
            ALU_SRC    = dec.alu_src;
            IMM_EXT    = {{(DATA_W-IMM_W){instr_q[IMM_LO+IMM_W-1]}},
                          instr_q[IMM_LO +: IMM_W]};
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RETIRE_CNT <= '0;
            SQUASH_CNT <= '0;
        end else if (state_q == WB) begin
            RETIRE_CNT <= RETIRE_CNT + 8'd1;
            if (squash_q)
                SQUASH_CNT <= SQUASH_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
module tb_regfile_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] INSTR;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic [7:0] RD_ONE, RD_TWO;
    logic [1:0] REG_SOURCE, REG_TWO, REG_DEST;
    logic       REGDST, REGWRITE;
    logic [1:0] ALU_OP;
    logic       ALU_SRC;
    logic [7:0] IMM_EXT;
    logic       DONE;
`ifdef CTRL_RETIRE_CNT_EN
    logic [7:0] RETIRE_CNT, SQUASH_CNT;
`endif

    int total = 0;
    int bad   = 0;

    // Values captured by issue() in each phase of one instruction
    logic [1:0] c_src, c_two_rd, c_alu_op, c_wb_two, c_wb_dest;
    logic       c_alu_src, c_busy, c_wb_wr, c_wb_dst, c_wb_done, c_wb_ready;
    logic       c_idle_ready, c_idle_done, c_idle_wr;
    logic [7:0] c_imm;

    regfile_seq_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .RD_ONE      (RD_ONE),
        .RD_TWO      (RD_TWO),
        .REG_SOURCE  (REG_SOURCE),
        .REG_TWO     (REG_TWO),
        .REG_DEST    (REG_DEST),
        .REGDST      (REGDST),
        .REGWRITE    (REGWRITE),
        .ALU_OP      (ALU_OP),
        .ALU_SRC     (ALU_SRC),
        .IMM_EXT     (IMM_EXT),
        .DONE        (DONE)
`ifdef CTRL_RETIRE_CNT_EN
       ,.RETIRE_CNT  (RETIRE_CNT),
        .SQUASH_CNT  (SQUASH_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Waits for INSTR_READY, hands over one instruction, then samples each
    // phase (READ, EXEC, WB, following IDLE) on the falling edge.
    task automatic issue(input logic [7:0] ins, input logic [7:0] r1, input logic [7:0] r2);
        int n = 0;
        @(negedge CLK);
        while (INSTR_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (INSTR_READY !== 1'b1) begin
            bad++;
            $display("FAIL issue_timeout ready=%b required=1", INSTR_READY);
        end
        total++;
        INSTR = ins; INSTR_VALID = 1'b1; RD_ONE = r1; RD_TWO = r2;
        @(posedge CLK); #1;
        INSTR_VALID = 1'b0;
        INSTR = ~ins;                       // must not be re-sampled
        @(negedge CLK);                     // READ
        c_src = REG_SOURCE; c_two_rd = REG_TWO;
        c_busy = REGWRITE | DONE | INSTR_READY;
        @(negedge CLK);                     // EXEC
        c_alu_op = ALU_OP; c_alu_src = ALU_SRC; c_imm = IMM_EXT;
        c_busy = c_busy | REGWRITE | DONE | INSTR_READY;
        @(negedge CLK);                     // WB
        c_wb_wr = REGWRITE; c_wb_dst = REGDST; c_wb_two = REG_TWO;
        c_wb_dest = REG_DEST; c_wb_done = DONE; c_wb_ready = INSTR_READY;
        @(negedge CLK);                     // IDLE again
        c_idle_ready = INSTR_READY; c_idle_done = DONE; c_idle_wr = REGWRITE;
    endtask

    task automatic test_reset();
        RST = 1'b1; INSTR = '0; INSTR_VALID = 1'b0; RD_ONE = '0; RD_TWO = '0;
        repeat (2) @(negedge CLK);
        total++;
        if ({INSTR_READY, REGWRITE, DONE, REGDST, ALU_SRC} !== 5'b0 ||
            {REG_SOURCE, REG_TWO, REG_DEST, ALU_OP} !== 8'h00 || IMM_EXT !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs ready=%b wr=%b done=%b src=%h imm=%h required all zero",
                     INSTR_READY, REGWRITE, DONE, REG_SOURCE, IMM_EXT);
        end
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (INSTR_READY !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b required=1", INSTR_READY);
        end
    endtask

    task automatic test_addi();
        issue(8'b10_00_01_01, 8'h00, 8'h00);
        total++;
        if (c_busy !== 1'b0) begin
            bad++; $display("FAIL addi_busy_outputs got=%b required=0", c_busy);
        end
        total++;
        if (c_src !== 2'd0 || c_two_rd !== 2'd1) begin
            bad++; $display("FAIL addi_read_addr src=%0d two=%0d required 0/1", c_src, c_two_rd);
        end
        total++;
        if (c_alu_op !== 2'b10 || c_alu_src !== 1'b1 || c_imm !== 8'h01) begin
            bad++; $display("FAIL addi_exec op=%b src=%b imm=%h required 10/1/01", c_alu_op, c_alu_src, c_imm);
        end
        total++;
        if (c_wb_wr !== 1'b1 || c_wb_dst !== 1'b0 || c_wb_two !== 2'd1 || c_wb_done !== 1'b1 || c_wb_ready !== 1'b0) begin
            bad++; $display("FAIL addi_wb wr=%b dst=%b two=%0d done=%b ready=%b required 1/0/1/1/0",
                            c_wb_wr, c_wb_dst, c_wb_two, c_wb_done, c_wb_ready);
        end
        total++;
        if (c_idle_ready !== 1'b1 || c_idle_done !== 1'b0 || c_idle_wr !== 1'b0) begin
            bad++; $display("FAIL addi_after ready=%b done=%b wr=%b required 1/0/0", c_idle_ready, c_idle_done, c_idle_wr);
        end
    endtask

    task automatic test_add_sub();
        issue(8'b00_01_10_11, 8'd5, 8'd7);
        total++;
        if (c_src !== 2'd1 || c_two_rd !== 2'd2 || c_alu_op !== 2'b00 || c_alu_src !== 1'b0) begin
            bad++; $display("FAIL add_exec src=%0d two=%0d op=%b asrc=%b required 1/2/00/0", c_src, c_two_rd, c_alu_op, c_alu_src);
        end
        total++;
        if (c_wb_wr !== 1'b1 || c_wb_dst !== 1'b1 || c_wb_dest !== 2'd3 || c_wb_done !== 1'b1) begin
            bad++; $display("FAIL add_wb wr=%b dst=%b dest=%0d done=%b required 1/1/3/1", c_wb_wr, c_wb_dst, c_wb_dest, c_wb_done);
        end
        issue(8'b01_11_00_10, 8'd9, 8'd2);
        total++;
        if (c_alu_op !== 2'b01 || c_alu_src !== 1'b0 || c_wb_wr !== 1'b1 || c_wb_dst !== 1'b1 || c_wb_dest !== 2'd2) begin
            bad++; $display("FAIL sub_ctrl op=%b asrc=%b wr=%b dst=%b dest=%0d required 01/0/1/1/2",
                            c_alu_op, c_alu_src, c_wb_wr, c_wb_dst, c_wb_dest);
        end
    endtask

    task automatic test_addi_neg();
        issue(8'b10_10_11_11, 8'h00, 8'h00);
        total++;
        if (c_imm !== 8'hFF || c_alu_op !== 2'b10 || c_alu_src !== 1'b1) begin
            bad++; $display("FAIL addi_neg imm=%h op=%b asrc=%b required FF/10/1", c_imm, c_alu_op, c_alu_src);
        end
        total++;
        if (c_wb_two !== 2'd3 || c_wb_dst !== 1'b0 || c_wb_wr !== 1'b1) begin
            bad++; $display("FAIL addi_neg_wb two=%0d dst=%b wr=%b required 3/0/1", c_wb_two, c_wb_dst, c_wb_wr);
        end
    endtask

    task automatic test_ske_squash();
        issue(8'b11_00_01_00, 8'h00, 8'h00);
        total++;
        if (c_wb_wr !== 1'b0 || c_wb_done !== 1'b1) begin
            bad++; $display("FAIL ske_eq_wb wr=%b done=%b required 0/1", c_wb_wr, c_wb_done);
        end
        issue(8'b00_01_10_11, 8'd5, 8'd7);
        total++;
        if (c_wb_wr !== 1'b0 || c_wb_done !== 1'b1) begin
            bad++; $display("FAIL squashed_add wr=%b done=%b required 0/1", c_wb_wr, c_wb_done);
        end
        issue(8'b00_01_10_11, 8'd5, 8'd7);
        total++;
        if (c_wb_wr !== 1'b1) begin
            bad++; $display("FAIL add_after_squash wr=%b required 1", c_wb_wr);
        end
    endtask

    task automatic test_ske_not_equal();
        issue(8'b11_00_01_00, 8'd3, 8'd4);
        issue(8'b00_01_10_11, 8'd3, 8'd3);
        total++;
        if (c_wb_wr !== 1'b1 || c_wb_done !== 1'b1) begin
            bad++; $display("FAIL ske_ne_add wr=%b done=%b required 1/1", c_wb_wr, c_wb_done);
        end
    endtask

    task automatic test_back_to_back();
        issue(8'b11_01_10_00, 8'h22, 8'h22);
        issue(8'b11_01_10_00, 8'h22, 8'h22);
        total++;
        if (c_wb_wr !== 1'b0 || c_wb_done !== 1'b1) begin
            bad++; $display("FAIL second_ske wr=%b done=%b required 0/1", c_wb_wr, c_wb_done);
        end
        issue(8'b00_00_00_01, 8'h22, 8'h22);
        total++;
        if (c_wb_wr !== 1'b1) begin
            bad++; $display("FAIL add_after_squashed_ske wr=%b required 1", c_wb_wr);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic seen;
`ifdef CTRL_RETIRE_CNT_EN
        total++;
        if (SQUASH_CNT !== 8'd2) begin
            bad++; $display("FAIL squash_cnt got=%0d required 2", SQUASH_CNT);
        end
`endif
        issue(8'b11_00_01_00, 8'h07, 8'h07);  // arms a skip
        @(negedge CLK);
        while (INSTR_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        INSTR = 8'b00_01_10_11; INSTR_VALID = 1'b1;
        @(posedge CLK); #1;
        INSTR_VALID = 1'b0;
        @(negedge CLK);                     // READ
        @(negedge CLK);                     // EXEC
        RST = 1'b1;
        #1;
        total++;
        if ({REGWRITE, DONE, INSTR_READY} !== 3'b000 || REG_SOURCE !== 2'd0 || ALU_OP !== 2'd0) begin
            bad++; $display("FAIL reset_mid_outputs wr=%b done=%b ready=%b src=%0d required all zero",
                            REGWRITE, DONE, INSTR_READY, REG_SOURCE);
        end
        seen = REGWRITE | DONE;
        @(negedge CLK);
        seen = seen | REGWRITE | DONE;
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (INSTR_READY !== 1'b1) begin
            bad++; $display("FAIL reset_mid_ready got=%b required=1", INSTR_READY);
        end
        for (int i = 0; i < 4; i++) begin
            seen = seen | REGWRITE | DONE;
            @(negedge CLK);
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL reset_mid_dropped write_or_done_seen=%b required 0", seen);
        end
        issue(8'b00_01_10_11, 8'd1, 8'd2);  // would be squashed if flag survived
        total++;
        if (c_wb_wr !== 1'b1) begin
            bad++; $display("FAIL reset_clears_squash wr=%b required 1", c_wb_wr);
        end
`ifdef CTRL_RETIRE_CNT_EN
        total++;
        if (RETIRE_CNT !== 8'd1 || SQUASH_CNT !== 8'd0) begin
            bad++; $display("FAIL cnt_after_reset retire=%0d squash=%0d required 1/0", RETIRE_CNT, SQUASH_CNT);
        end
        for (int i = 0; i < 255; i++)
            issue(8'b10_00_00_01, 8'h00, 8'h00);
        total++;
        if (RETIRE_CNT !== 8'd0) begin
            bad++; $display("FAIL retire_cnt_wrap got=%0d required 0", RETIRE_CNT);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add_sub();
        test_addi_neg();
        test_ske_squash();
        test_ske_not_equal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
